// File: rtl/axi_lite_slave_mem.sv
`default_nettype none
// ==== axi_lite_slave_mem : AXI4-Lite slave with a byte-wide memory, one transaction at a time ====
// ==== Revision 1.0 ====
module axi_lite_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int BUFFER_SIZE = 4096,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready
);

  localparam int         IDX_W       = $clog2(BUFFER_SIZE);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP} state_t;

  state_t                state;
  logic                  last_write;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] mem [BUFFER_SIZE];

  logic ar_in_range;
  logic wr_in_range;
  logic wr_en;

  // Full-width compare so addresses beyond the buffer never alias into it.
  assign ar_in_range = araddr < ADDR_WIDTH'(BUFFER_SIZE);
  assign wr_in_range = addr < ADDR_WIDTH'(BUFFER_SIZE);
  assign wr_en       = (state == WDATA) && wvalid && wready && wstrb[0] && wr_in_range;

  // Storage has no reset so contents survive areset_n.
  always_ff @(posedge aclk) begin
    if (wr_en) mem[addr[IDX_W-1:0]] <= wdata;
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state      <= IDLE;
      last_write <= 1'b1;
      addr       <= '0;
      arready    <= 1'b0;
      rvalid     <= 1'b0;
      rdata      <= '0;
      rresp      <= RESP_OKAY;
      awready    <= 1'b0;
      wready     <= 1'b0;
      bvalid     <= 1'b0;
      bresp      <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (arvalid && (!awvalid || last_write)) begin
            state   <= RADDR;
            arready <= 1'b1;
          end else if (awvalid) begin
            state   <= WADDR;
            awready <= 1'b1;
          end
        end
        RADDR: begin
          if (arvalid && arready) begin
            addr    <= araddr;
            arready <= 1'b0;
            rvalid  <= 1'b1;
            state   <= RDATA;
            if (ar_in_range) begin
              rdata <= mem[araddr[IDX_W-1:0]];
              rresp <= RESP_OKAY;
            end else begin
              rdata <= '0;
              rresp <= RESP_SLVERR;
            end
          end
        end
        RDATA: begin
          if (rready) begin
            rvalid     <= 1'b0;
            last_write <= 1'b0;
            state      <= IDLE;
          end
        end
        WADDR: begin
          if (awvalid && awready) begin
            addr    <= awaddr;
            awready <= 1'b0;
            wready  <= 1'b1;
            state   <= WDATA;
          end
        end
        WDATA: begin
          if (wvalid && wready) begin
            wready <= 1'b0;
            bvalid <= 1'b1;
            bresp  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            state  <= WRESP;
          end
        end
        WRESP: begin
          if (bready) begin
            bvalid     <= 1'b0;
            last_write <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_slave_mem.sv
`default_nettype none
// Testbench for axi_lite_slave_mem: directed scenarios plus randomized traffic against a byte-array model.
module tb_axi_lite_slave_mem;

  localparam int AW = 32;
  localparam int DW = 8;
  localparam int BS = 4096;

  logic          aclk = 1'b0;
  logic          areset_n;
  logic [AW-1:0] araddr, awaddr;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] rdata, wdata;
  logic [1:0]    rresp, bresp;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [0:0]    wstrb;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [BS];
  bit         known   [BS];

  axi_lite_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUFFER_SIZE(BS)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  function automatic logic [16:0] all_outs();
    return {arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    araddr = '0; arvalid = 0; rready = 0;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    areset_n = 0;
    repeat (2) tick();
    areset_n = 1;
    tick();
  endtask

  task automatic model_write(input logic [31:0] a, input logic [7:0] d, input logic s);
    if (a < BS && s) begin
      ref_mem[a[11:0]] = d;
      known[a[11:0]]   = 1'b1;
    end
  endtask

  // Full read transaction; rready held low for 'hold' cycles after rvalid.
  task automatic axi_read(input logic [31:0] a, input int hold, output logic [7:0] data,
                          output logic [1:0] resp, output int cyc, output bit stable, output bit done);
    bit hs;
    araddr = a; arvalid = 1; rready = 0;
    cyc = 0; stable = 1; done = 0; data = '0; resp = '0;
    while (!rvalid) begin
      hs = arvalid && arready;
      tick();
      cyc++;
      if (hs) arvalid = 0;
      if (cyc > 30) begin
        checks++; errors++;
        $display("FAIL read_timeout addr=%h got no rvalid, required rvalid within 30 cycles", a);
        arvalid = 0;
        return;
      end
    end
    data = rdata; resp = rresp;
    repeat (hold) begin
      tick();
      if (!rvalid || rdata !== data || rresp !== resp) stable = 0;
    end
    rready = 1;
    tick();
    rready = 0;
    done = !rvalid;
  endtask

  // Full write transaction; AW and W presented together, bready held low for 'hold' cycles.
  task automatic axi_write(input logic [31:0] a, input logic [7:0] d, input logic s, input int hold,
                           output logic [1:0] resp, output int cyc, output bit stable, output bit done);
    bit aw_hs, w_hs;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 0;
    cyc = 0; stable = 1; done = 0; resp = '0;
    while (!bvalid) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      cyc++;
      if (aw_hs) awvalid = 0;
      if (w_hs)  wvalid = 0;
      if (cyc > 30) begin
        checks++; errors++;
        $display("FAIL write_timeout addr=%h got no bvalid, required bvalid within 30 cycles", a);
        awvalid = 0; wvalid = 0;
        return;
      end
    end
    resp = bresp;
    repeat (hold) begin
      tick();
      if (!bvalid || bresp !== resp) stable = 0;
    end
    bready = 1;
    tick();
    bready = 0;
    done = !bvalid;
  endtask

  task automatic test_reset();
    idle_inputs();
    areset_n = 1;
    tick();
    #2 areset_n = 0;
    #1;
    checks++;
    if (all_outs() !== 17'd0) begin
      errors++; $display("FAIL reset_assert outputs=%h required 0", all_outs());
    end
    tick(); areset_n = 1; tick();
    checks++;
    if (all_outs() !== 17'd0) begin
      errors++; $display("FAIL reset_release outputs=%h required 0", all_outs());
    end
  endtask

  task automatic test_write_read();
    logic [7:0] d; logic [1:0] r; int c; bit st, dn;
    axi_write(32'h4, 8'hA5, 1'b1, 0, r, c, st, dn);
    model_write(32'h4, 8'hA5, 1'b1);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL wr_bresp got=%b required=00", r); end
    checks++;
    if (c != 3) begin errors++; $display("FAIL wr_latency got=%0d required=3", c); end
    axi_read(32'h4, 0, d, r, c, st, dn);
    checks++;
    if (d !== 8'hA5 || r !== 2'b00) begin
      errors++; $display("FAIL rd_data got=%h/%b required=a5/00", d, r);
    end
    checks++;
    if (c != 2) begin errors++; $display("FAIL rd_latency got=%0d required=2", c); end
  endtask

  task automatic test_strobe();
    logic [7:0] d; logic [1:0] r; int c; bit st, dn;
    axi_write(32'h14, 8'h11, 1'b1, 0, r, c, st, dn);
    model_write(32'h14, 8'h11, 1'b1);
    axi_write(32'h14, 8'h3C, 1'b0, 0, r, c, st, dn);
    model_write(32'h14, 8'h3C, 1'b0);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL strb0_bresp got=%b required=00", r); end
    axi_read(32'h14, 0, d, r, c, st, dn);
    checks++;
    if (d !== 8'h11) begin errors++; $display("FAIL strb0_data got=%h required=11", d); end
  endtask

  task automatic test_out_of_range();
    logic [7:0] d; logic [1:0] r; int c; bit st, dn;
    axi_write(32'h0, 8'h5A, 1'b1, 0, r, c, st, dn);
    model_write(32'h0, 8'h5A, 1'b1);
    axi_read(32'h1000, 0, d, r, c, st, dn);
    checks++;
    if (d !== 8'h00 || r !== 2'b10) begin
      errors++; $display("FAIL oor_read got=%h/%b required=00/10", d, r);
    end
    axi_write(32'h1000, 8'h55, 1'b1, 0, r, c, st, dn);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL oor_bresp got=%b required=10", r); end
    axi_read(32'h0, 0, d, r, c, st, dn);
    checks++;
    if (d !== 8'h5A || r !== 2'b00) begin
      errors++; $display("FAIL oor_alias got=%h/%b required=5a/00", d, r);
    end
  endtask

  task automatic test_arbitration();
    bit ar_hs, aw_hs;
    int n, cyc;
    logic [3:0] seq;
    do_reset();
    araddr = 32'h4; awaddr = 32'h40; wdata = 8'hEE; wstrb = 1'b0;
    arvalid = 1; awvalid = 1; wvalid = 1; rready = 1; bready = 1;
    n = 0; cyc = 0; seq = '0;
    while (n < 4 && cyc < 60) begin
      ar_hs = arvalid && arready;
      aw_hs = awvalid && awready;
      tick();
      cyc++;
      if (ar_hs) begin seq[n] = 1'b0; n++; end
      else if (aw_hs) begin seq[n] = 1'b1; n++; end
    end
    arvalid = 0; awvalid = 0;
    repeat (4) tick();
    wvalid = 0; rready = 0; bready = 0;
    checks++;
    if (n != 4) begin errors++; $display("FAIL arb_count got=%0d required=4", n); end
    checks++;
    if (seq !== 4'b1010) begin errors++; $display("FAIL arb_order got=%b required=1010 (W=1,lsb first)", seq); end
  endtask

  task automatic test_backpressure();
    logic [7:0] d; logic [1:0] r; int c; bit st, dn;
    axi_write(32'h50, 8'hC3, 1'b1, 0, r, c, st, dn);
    model_write(32'h50, 8'hC3, 1'b1);
    axi_read(32'h50, 5, d, r, c, st, dn);
    checks++;
    if (!st || !dn) begin errors++; $display("FAIL rd_backpressure stable=%0b done=%0b required 1/1", st, dn); end
    checks++;
    if (d !== 8'hC3) begin errors++; $display("FAIL rd_bp_data got=%h required=c3", d); end
    axi_write(32'h2000, 8'h7E, 1'b1, 5, r, c, st, dn);
    checks++;
    if (!st || !dn || r !== 2'b10) begin
      errors++; $display("FAIL wr_backpressure stable=%0b done=%0b bresp=%b required 1/1/10", st, dn, r);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [7:0] d; logic [1:0] r; int c; bit st, dn, hs;
    axi_write(32'h30, 8'h77, 1'b1, 0, r, c, st, dn);
    model_write(32'h30, 8'h77, 1'b1);
    awaddr = 32'h30; wdata = 8'h99; wstrb = 1'b1; awvalid = 1; wvalid = 0;
    c = 0;
    while (!wready && c < 20) begin
      hs = awvalid && awready;
      tick(); c++;
      if (hs) awvalid = 0;
    end
    awvalid = 0;
    checks++;
    if (!wready) begin errors++; $display("FAIL mid_wdata_reach wready=%b required=1", wready); end
    #3 areset_n = 0;
    #1;
    checks++;
    if (all_outs() !== 17'd0) begin errors++; $display("FAIL mid_reset_outs got=%h required 0", all_outs()); end
    #2 areset_n = 1;
    tick();
    checks++;
    if (all_outs() !== 17'd0) begin errors++; $display("FAIL mid_reset_idle got=%h required 0", all_outs()); end
    araddr = 32'h30; awaddr = 32'h40; wstrb = 1'b0; arvalid = 1; awvalid = 1;
    tick();
    awvalid = 0;
    checks++;
    if (arready !== 1'b1 || awready !== 1'b0) begin
      errors++; $display("FAIL mid_reset_first arready=%b awready=%b required 1/0", arready, awready);
    end
    tick();
    arvalid = 0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 8'h77 || rresp !== 2'b00) begin
      errors++; $display("FAIL mid_reset_keep rvalid=%b rdata=%h rresp=%b required 1/77/00", rvalid, rdata, rresp);
    end
    rready = 1; tick(); rready = 0;
  endtask

  task automatic test_random();
    logic [31:0] a; logic [7:0] dv, d; logic s; logic [1:0] r; int c, hold, sel; bit st, dn;
    for (int i = 0; i < 40; i++) begin
      sel  = $urandom_range(0, 7);
      a    = (sel == 0) ? 32'h1000 + $urandom_range(0, 1000) :
             (sel == 1) ? 32'($urandom) : 32'($urandom_range(0, 63));
      dv   = 8'($urandom_range(0, 255));
      s    = ($urandom_range(0, 3) != 0);
      hold = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        axi_write(a, dv, s, hold, r, c, st, dn);
        checks++;
        if (r !== ((a < BS) ? 2'b00 : 2'b10) || c != 3 || !st || !dn) begin
          errors++;
          $display("FAIL rand_write addr=%h bresp=%b lat=%0d st=%0b dn=%0b required %b/3/1/1",
                   a, r, c, st, dn, (a < BS) ? 2'b00 : 2'b10);
        end
        model_write(a, dv, s);
      end else begin
        axi_read(a, hold, d, r, c, st, dn);
        checks++;
        if (a >= BS) begin
          if (d !== 8'h00 || r !== 2'b10 || c != 2 || !st || !dn) begin
            errors++; $display("FAIL rand_read_oor addr=%h got=%h/%b lat=%0d required 00/10/2", a, d, r, c);
          end
        end else if (r !== 2'b00 || c != 2 || !st || !dn || (known[a[11:0]] && d !== ref_mem[a[11:0]])) begin
          errors++;
          $display("FAIL rand_read addr=%h got=%h/%b lat=%0d required %h/00/2", a, d, r, c, ref_mem[a[11:0]]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < BS; i++) known[i] = 1'b0;
    do_reset();
    test_reset();
    test_write_read();
    test_strobe();
    test_out_of_range();
    test_arbitration();
    test_backpressure();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
